// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for the EX stage.
// Picks a forward source per operand (youngest matching producer wins),
// raises stall when the youngest match is not ready, tracks long-latency
// destinations in a per-register scoreboard, checks WAW against it, and
// counts stall cycles with a saturating counter.
module fwd_hazard_ctrl #(
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 2,
    parameter int RA_W    = 5,
    parameter int SEL_W   = $clog2(NUM_FWD + 1),
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC*RA_W-1:0]    rs_addr_ex,
    input  logic [NUM_SRC-1:0]         rs_valid_ex,
    input  logic [NUM_FWD*RA_W-1:0]    rd_addr_fwd,
    input  logic [NUM_FWD-1:0]         rd_valid_fwd,
    input  logic [NUM_FWD-1:0]         res_ready_fwd,
    input  logic                       lo_issue,
    input  logic [RA_W-1:0]            lo_issue_rd,
    input  logic                       lo_done,
    input  logic [RA_W-1:0]            lo_done_rd,
    input  logic [RA_W-1:0]            id_rd,
    input  logic                       id_rd_valid,
    input  logic                       flush,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
    output logic                       stall,
    output logic [(2**RA_W)-1:0]       pending,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int NUM_REG = 2 ** RA_W;

    logic [NUM_REG-1:0]       pending_q;
    logic [NUM_REG-1:0]       pending_d;
    logic [CNT_W-1:0]         stall_cnt_q;
    logic [CNT_W-1:0]         stall_cnt_d;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel_s;
    logic [NUM_SRC-1:0]       op_haz_s;
    logic [NUM_SRC-1:0]       sb_haz_s;
    logic                     waw_haz_s;
    logic                     stall_s;

    // Per-operand forward select plus forwarding and scoreboard hazards.
    always_comb begin : operand_scan
        logic [RA_W-1:0] rs_v;
        logic            found_v;
        fwd_sel_s = '0;
        op_haz_s  = '0;
        sb_haz_s  = '0;
        rs_v      = '0;
        found_v   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rs_v    = rs_addr_ex[i*RA_W +: RA_W];
            found_v = 1'b0;
            if (rs_valid_ex[i] && (rs_v != '0)) begin
                // Youngest stage first; an unready younger match blocks older stages.
                for (int k = 0; k < NUM_FWD; k++) begin
                    if (!found_v && rd_valid_fwd[k] &&
                        (rd_addr_fwd[k*RA_W +: RA_W] == rs_v)) begin
                        found_v = 1'b1;
                        if (res_ready_fwd[k]) begin
                            fwd_sel_s[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                        end else begin
                            op_haz_s[i] = 1'b1;
                        end
                    end else begin
                        found_v = found_v;
                    end
                end
                // A same-cycle long-op writeback reaches EX through the WB forward path.
                if (pending_q[rs_v] && !(lo_done && (lo_done_rd == rs_v))) begin
                    sb_haz_s[i] = 1'b1;
                end else begin
                    sb_haz_s[i] = 1'b0;
                end
            end else begin
                found_v = 1'b0;
            end
        end
    end

    // WAW check of the EX instruction's destination against outstanding long ops.
    always_comb begin
        waw_haz_s = 1'b0;
        if (id_rd_valid && (id_rd != '0) && pending_q[id_rd] &&
            !(lo_done && (lo_done_rd == id_rd))) begin
            waw_haz_s = 1'b1;
        end else begin
            waw_haz_s = 1'b0;
        end
    end

    // Combine every hazard source into the pipeline stall.
    always_comb begin
        stall_s = (|op_haz_s) | (|sb_haz_s) | waw_haz_s;
    end

    // Scoreboard next state: done clears first, then a real issue sets (issue wins).
    always_comb begin
        pending_d = pending_q;
        if (lo_done && (lo_done_rd != '0)) begin
            pending_d[lo_done_rd] = 1'b0;
        end else begin
            pending_d = pending_d;
        end
        if (lo_issue && !flush && !stall_s && (lo_issue_rd != '0)) begin
            pending_d[lo_issue_rd] = 1'b1;
        end else begin
            pending_d = pending_d;
        end
        pending_d[0] = 1'b0;
    end

    // Stall counter next state, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_sel   = fwd_sel_s;
    assign stall     = stall_s;
    assign pending   = pending_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed testbench for fwd_hazard_ctrl with hand-computed expectations.
module tb_fwd_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rs_addr_ex;
    logic [1:0]  rs_valid_ex;
    logic [9:0]  rd_addr_fwd;
    logic [1:0]  rd_valid_fwd;
    logic [1:0]  res_ready_fwd;
    logic        lo_issue;
    logic [4:0]  lo_issue_rd;
    logic        lo_done;
    logic [4:0]  lo_done_rd;
    logic [4:0]  id_rd;
    logic        id_rd_valid;
    logic        flush;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic [31:0] pending;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    fwd_hazard_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rs_addr_ex    (rs_addr_ex),
        .rs_valid_ex   (rs_valid_ex),
        .rd_addr_fwd   (rd_addr_fwd),
        .rd_valid_fwd  (rd_valid_fwd),
        .res_ready_fwd (res_ready_fwd),
        .lo_issue      (lo_issue),
        .lo_issue_rd   (lo_issue_rd),
        .lo_done       (lo_done),
        .lo_done_rd    (lo_done_rd),
        .id_rd         (id_rd),
        .id_rd_valid   (id_rd_valid),
        .flush         (flush),
        .fwd_sel       (fwd_sel),
        .stall         (stall),
        .pending       (pending),
        .stall_cnt     (stall_cnt)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        rs_addr_ex    = 10'd0;
        rs_valid_ex   = 2'b00;
        rd_addr_fwd   = 10'd0;
        rd_valid_fwd  = 2'b00;
        res_ready_fwd = 2'b00;
        lo_issue      = 1'b0;
        lo_issue_rd   = 5'd0;
        lo_done       = 1'b0;
        lo_done_rd    = 5'd0;
        id_rd         = 5'd0;
        id_rd_valid   = 1'b0;
        flush         = 1'b0;
    endtask

    // Wait for the next active edge and sample just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #2;
        check_val("rst_pending", 64'(pending), 64'h0);
        check_val("rst_cnt", 64'(stall_cnt), 64'h0);
        check_val("rst_sel", 64'(fwd_sel), 64'h0);
        check_val("rst_stall", 64'(stall), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: both stages write x5 and are ready; youngest wins.
        @(negedge clk);
        rs_addr_ex = {5'd0, 5'd5}; rs_valid_ex = 2'b01;
        rd_addr_fwd = {5'd5, 5'd5}; rd_valid_fwd = 2'b11; res_ready_fwd = 2'b11;
        #1;
        check_val("t1_sel_young", 64'(fwd_sel), 64'h1);
        check_val("t1_stall", 64'(stall), 64'h0);
        rd_addr_fwd = {5'd5, 5'd6};
        #1;
        check_val("t1_sel_old", 64'(fwd_sel), 64'h2);
        idle_inputs();

        // 2: unready load in stage0 blocks older ready stage1.
        @(negedge clk);
        rs_addr_ex = {5'd7, 5'd0}; rs_valid_ex = 2'b10;
        rd_addr_fwd = {5'd7, 5'd7}; rd_valid_fwd = 2'b11; res_ready_fwd = 2'b10;
        #1;
        check_val("t2_sel_blk", 64'(fwd_sel), 64'h0);
        check_val("t2_stall", 64'(stall), 64'h1);
        rd_valid_fwd = 2'b10;
        #1;
        check_val("t2_sel_wb", 64'(fwd_sel), 64'h8);
        check_val("t2_stall_clr", 64'(stall), 64'h0);
        idle_inputs();

        // 3: x0 never forwards and never becomes pending.
        @(negedge clk);
        rs_addr_ex = 10'd0; rs_valid_ex = 2'b01;
        rd_addr_fwd = 10'd0; rd_valid_fwd = 2'b01; res_ready_fwd = 2'b01;
        lo_issue = 1'b1; lo_issue_rd = 5'd0;
        #1;
        check_val("t3_sel_x0", 64'(fwd_sel), 64'h0);
        check_val("t3_stall_x0", 64'(stall), 64'h0);
        tick();
        check_val("t3_pend_x0", 64'(pending), 64'h0);
        idle_inputs();

        // 4: scoreboard stall on x9, counter, ignored issue while stalled, lo_done bypass.
        @(negedge clk);
        lo_issue = 1'b1; lo_issue_rd = 5'd9;
        tick();
        check_val("t4_pend9", 64'(pending), 64'h200);
        @(negedge clk);
        idle_inputs();
        rs_addr_ex = {5'd0, 5'd9}; rs_valid_ex = 2'b01;
        #1;
        check_val("t4_stall", 64'(stall), 64'h1);
        tick();
        check_val("t4_cnt1", 64'(stall_cnt), 64'h1);
        @(negedge clk);
        lo_issue = 1'b1; lo_issue_rd = 5'd10;
        tick();
        check_val("t4_cnt2", 64'(stall_cnt), 64'h2);
        check_val("t4_no_issue", 64'(pending), 64'h200);
        @(negedge clk);
        lo_issue = 1'b0; lo_issue_rd = 5'd0;
        lo_done = 1'b1; lo_done_rd = 5'd9;
        #1;
        check_val("t4_bypass", 64'(stall), 64'h0);
        tick();
        check_val("t4_pend_clr", 64'(pending), 64'h0);
        check_val("t4_cnt_hold", 64'(stall_cnt), 64'h2);
        @(negedge clk);
        idle_inputs();

        // 5: issue/done collision, flush kill, WAW.
        lo_issue = 1'b1; lo_issue_rd = 5'd3;
        tick();
        @(negedge clk);
        lo_done = 1'b1; lo_done_rd = 5'd3;
        tick();
        check_val("t5_issue_wins", 64'(pending), 64'h8);
        @(negedge clk);
        idle_inputs();
        lo_issue = 1'b1; lo_issue_rd = 5'd4; flush = 1'b1;
        tick();
        check_val("t5_flush", 64'(pending), 64'h8);
        @(negedge clk);
        idle_inputs();
        id_rd = 5'd3; id_rd_valid = 1'b1;
        #1;
        check_val("t5_waw", 64'(stall), 64'h1);
        lo_done = 1'b1; lo_done_rd = 5'd3;
        #1;
        check_val("t5_waw_clr", 64'(stall), 64'h0);
        tick();
        check_val("t5_pend_clr", 64'(pending), 64'h0);
        check_val("t5_cnt", 64'(stall_cnt), 64'h2);
        @(negedge clk);
        idle_inputs();

        // 6: asynchronous reset mid-operation, then post-reset no-op done.
        lo_issue = 1'b1; lo_issue_rd = 5'd12;
        tick();
        check_val("t6_pend12", 64'(pending), 64'h1000);
        idle_inputs();
        #1;
        rst_n = 1'b0;
        #1;
        check_val("t6_async_pend", 64'(pending), 64'h0);
        check_val("t6_async_cnt", 64'(stall_cnt), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        lo_done = 1'b1; lo_done_rd = 5'd12;
        tick();
        check_val("t6_done_noop", 64'(pending), 64'h0);

        // Counter saturation with a held scoreboard stall on x20.
        @(negedge clk);
        idle_inputs();
        lo_issue = 1'b1; lo_issue_rd = 5'd20;
        tick();
        @(negedge clk);
        idle_inputs();
        rs_addr_ex = {5'd20, 5'd0}; rs_valid_ex = 2'b10;
        repeat (65534) @(posedge clk);
        #1;
        check_val("t6_cnt_fffe", 64'(stall_cnt), 64'hFFFE);
        tick();
        check_val("t6_cnt_ffff", 64'(stall_cnt), 64'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        check_val("t6_cnt_sat", 64'(stall_cnt), 64'hFFFF);
        @(negedge clk);
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
